// File: rtl/timer_sound_mixer.sv
// Box-filter decimator and mixer for the three timer outputs plus the beeper.
// Counts high levels per tce tick over a window of DECIM ticks and emits one 8-bit PCM sample per window.
module timer_sound_mixer #(
  parameter int LOG2_DECIM = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tce,
  input  logic [2:0] tout,
  input  logic       beeper,
  input  logic [3:0] mute,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       clip,
  input  logic       clip_clr
);

  localparam int DECIM = 2**LOG2_DECIM;
  localparam int AW    = LOG2_DECIM + 1;
  localparam int SW    = LOG2_DECIM + 3;
  localparam int SHIFT = LOG2_DECIM - 6;

  logic [3:0]            src;
  logic [AW-1:0]         acc_q [4];
  logic [AW-1:0]         acc_d [4];
  logic [LOG2_DECIM-1:0] tcnt_q, tcnt_d;
  logic [7:0]            sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  clip_q, clip_d;
  logic                  close;
  logic [SW-1:0]         sum;
  logic [SW-1:0]         scaled;

  function automatic logic over_range(input logic [SW-1:0] v);
    return v > SW'(255);
  endfunction

  function automatic logic [7:0] sat8(input logic [SW-1:0] v);
    return over_range(v) ? 8'hFF : v[7:0];
  endfunction

  assign src = {beeper, tout} & ~mute;

  always_comb begin
    close = tce && (tcnt_q == LOG2_DECIM'(DECIM - 1));
    // The closing tick's bits are folded into the sum, never into the accumulators.
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      sum = sum + SW'(acc_q[i]) + SW'(src[i]);
    end
    scaled   = sum >> SHIFT;
    tcnt_d   = tcnt_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    clip_d   = clip_q & ~clip_clr;
    for (int i = 0; i < 4; i++) begin
      acc_d[i] = acc_q[i];
    end
    if (close) begin
      for (int i = 0; i < 4; i++) begin
        acc_d[i] = '0;
      end
      tcnt_d   = '0;
      sample_d = sat8(scaled);
      valid_d  = 1'b1;
      if (over_range(scaled)) clip_d = 1'b1;
    end else if (tce) begin
      for (int i = 0; i < 4; i++) begin
        acc_d[i] = acc_q[i] + AW'(src[i]);
      end
      tcnt_d = tcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= '0;
      end
      tcnt_q   <= '0;
      sample_q <= 8'h00;
      valid_q  <= 1'b0;
      clip_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= acc_d[i];
      end
      tcnt_q   <= tcnt_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      clip_q   <= clip_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign clip         = clip_q;

endmodule
